// File: rtl/fade_pkg.sv
// Shared types and helpers for the RGB colour-wheel fader: hue state encoding
// and the state-walk functions used by the top-level FSM.
package fade_pkg;

  typedef enum logic [2:0] {
    GREEN_INC = 3'd0,
    RED_DEC   = 3'd1,
    BLUE_INC  = 3'd2,
    GREEN_DEC = 3'd3,
    RED_INC   = 3'd4,
    BLUE_DEC  = 3'd5
  } state_t;

  function automatic logic is_inc(input state_t s);
    return (s == GREEN_INC) || (s == BLUE_INC) || (s == RED_INC);
  endfunction

  // Hue order wraps from BLUE_DEC back to GREEN_INC.
  function automatic state_t next_hue(input state_t s);
    return (s == BLUE_DEC) ? GREEN_INC : state_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output pin: on while the shared counter is below the duty.
// Polarity is active-low unless RGB_ACTIVE_HIGH_EN is defined.
module pwm_channel #(
  parameter int W = 10
) (
  input  logic [W-1:0] counter,
  input  logic [W-1:0] duty,
  output logic         pin
);

  logic on;

  assign on = (counter < duty);

`ifdef RGB_ACTIVE_HIGH_EN
  assign pin = on;
`else
  assign pin = ~on;
`endif

endmodule

// File: rtl/rgb_fade_top.sv
// Colour-wheel fader for one RGB LED: six-state hue FSM, step timer, shared PWM
// counter and three pwm_channel pins. Build option RGB_ACTIVE_HIGH_EN inverts pins.
module rgb_fade_top
  import fade_pkg::*;
#(
  parameter int PWM_INTERVAL  = 1000,
  parameter int STEP_INTERVAL = 10000,
  parameter int STEP_SIZE     = 5
) (
  input  logic clk,
  input  logic rst_n,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B
);

  localparam int PW = $clog2(PWM_INTERVAL + 1);
  localparam int SW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

  localparam logic [PW-1:0] FULL      = PW'(PWM_INTERVAL);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_INTERVAL - 1);
  localparam logic [PW:0]   STEP_EXT  = (PW+1)'(STEP_SIZE);

  state_t        current_state;
  logic [PW-1:0] pwm_value;
  logic [PW-1:0] pwm_cnt;
  logic [SW-1:0] step_cnt;
  logic          tick;
  logic [PW-1:0] duty_r, duty_g, duty_b;

  // Sums are formed one bit wider so the saturation test cannot wrap.
  function automatic logic up_done(input logic [PW-1:0] v);
    logic [PW:0] s;
    s = {1'b0, v} + STEP_EXT;
    return s >= {1'b0, FULL};
  endfunction

  function automatic logic [PW-1:0] ramp_up(input logic [PW-1:0] v);
    logic [PW:0] s;
    s = {1'b0, v} + STEP_EXT;
    return up_done(v) ? FULL : s[PW-1:0];
  endfunction

  function automatic logic down_done(input logic [PW-1:0] v);
    return {1'b0, v} <= STEP_EXT;
  endfunction

  function automatic logic [PW-1:0] ramp_down(input logic [PW-1:0] v);
    return down_done(v) ? '0 : (v - STEP_EXT[PW-1:0]);
  endfunction

  assign tick = (step_cnt == STEP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      current_state <= GREEN_INC;
      pwm_value     <= '0;
      step_cnt      <= '0;
      pwm_cnt       <= '0;
    end else begin
      pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      if (tick) begin
        if (is_inc(current_state)) begin
          pwm_value <= ramp_up(pwm_value);
          if (up_done(pwm_value)) current_state <= next_hue(current_state);
        end else begin
          pwm_value <= ramp_down(pwm_value);
          if (down_done(pwm_value)) current_state <= next_hue(current_state);
        end
      end
    end
  end

  // Exactly one channel ramps per state; the others are held at full or off.
  always_comb begin
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    case (current_state)
      GREEN_INC: begin duty_r = FULL;      duty_g = pwm_value; end
      RED_DEC:   begin duty_r = pwm_value; duty_g = FULL;      end
      BLUE_INC:  begin duty_g = FULL;      duty_b = pwm_value; end
      GREEN_DEC: begin duty_g = pwm_value; duty_b = FULL;      end
      RED_INC:   begin duty_r = pwm_value; duty_b = FULL;      end
      BLUE_DEC:  begin duty_r = FULL;      duty_b = pwm_value; end
      default:   begin duty_r = '0;        duty_g = '0;        end
    endcase
  end

  pwm_channel #(.W(PW)) u_red   (.counter(pwm_cnt), .duty(duty_r), .pin(RGB_R));
  pwm_channel #(.W(PW)) u_green (.counter(pwm_cnt), .duty(duty_g), .pin(RGB_G));
  pwm_channel #(.W(PW)) u_blue  (.counter(pwm_cnt), .duty(duty_b), .pin(RGB_B));

endmodule

// File: tb/tb_rgb_fade_top.sv
// Bench for rgb_fade_top: two instances (STEP_SIZE 2 and 3) checked every cycle
// against an integer model of the colour wheel, plus hand-computed checkpoints.
module tb_rgb_fade_top;
  import fade_pkg::*;

  localparam int PI = 10;
  localparam int SI = 4;

`ifdef RGB_ACTIVE_HIGH_EN
  localparam int ON = 1;
`else
  localparam int ON = 0;
`endif
  localparam int OFF = 1 - ON;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ra, ga, ba, rb, gb, bb;

  always #5 clk = ~clk;

  rgb_fade_top #(.PWM_INTERVAL(PI), .STEP_INTERVAL(SI), .STEP_SIZE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .RGB_R(ra), .RGB_G(ga), .RGB_B(ba));

  rgb_fade_top #(.PWM_INTERVAL(PI), .STEP_INTERVAL(SI), .STEP_SIZE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .RGB_R(rb), .RGB_G(gb), .RGB_B(bb));

  int compared = 0;
  int mismatched = 0;
  bit check_en = 1'b0;

  // Model state per instance: hue index 0..5 in wheel order, level, cycle counts.
  int hue [2];
  int lvl [2];
  int clocks [2];

  // Hue h ramps channel RAMP_CH[h] and holds channel FULL_CH[h] at full (0=R,1=G,2=B).
  int ramp_ch [6] = '{1, 0, 2, 1, 0, 2};
  int full_ch [6] = '{0, 1, 1, 2, 2, 0};

  function automatic int step_of(input int m);
    return (m == 0) ? 2 : 3;
  endfunction

  function automatic int exp_pin(input int m, input int ch);
    int duty;
    int phase;
    if (ch == ramp_ch[hue[m]]) duty = lvl[m];
    else if (ch == full_ch[hue[m]]) duty = PI;
    else duty = 0;
    phase = clocks[m] % PI;
    return (phase < duty) ? ON : OFF;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advance: one clock of elapsed time, level moves every SI-th clock.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        hue[m] = 0;
        lvl[m] = 0;
        clocks[m] = 0;
      end else begin
        clocks[m] = clocks[m] + 1;
        if (clocks[m] % SI == 0) begin
          if (hue[m] % 2 == 0) begin
            if (lvl[m] + step_of(m) >= PI) begin
              lvl[m] = PI;
              hue[m] = (hue[m] + 1) % 6;
            end else lvl[m] = lvl[m] + step_of(m);
          end else begin
            if (lvl[m] <= step_of(m)) begin
              lvl[m] = 0;
              hue[m] = (hue[m] + 1) % 6;
            end else lvl[m] = lvl[m] - step_of(m);
          end
        end
      end
    end
    if (!rst_n) check_en = 1'b1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("a_state", int'(dut_a.current_state), hue[0]);
      check("a_value", int'(dut_a.pwm_value), lvl[0]);
      check("a_R", int'(ra), exp_pin(0, 0));
      check("a_G", int'(ga), exp_pin(0, 1));
      check("a_B", int'(ba), exp_pin(0, 2));
      check("b_state", int'(dut_b.current_state), hue[1]);
      check("b_value", int'(dut_b.pwm_value), lvl[1]);
      check("b_R", int'(rb), exp_pin(1, 0));
      check("b_G", int'(gb), exp_pin(1, 1));
      check("b_B", int'(bb), exp_pin(1, 2));
      check("b_range", int'(dut_b.pwm_value <= 10), 1);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    run(3);
    check("lit_rst_state", int'(dut_a.current_state), int'(GREEN_INC));
    check("lit_rst_value", int'(dut_a.pwm_value), 0);
    check("lit_rst_R", int'(ra), ON);
    check("lit_rst_G", int'(ga), OFF);
    check("lit_rst_B", int'(ba), OFF);
    rst_n = 1'b1;

    run(3);
    check("lit_c3_value", int'(dut_a.pwm_value), 0);
    check("lit_c3_G", int'(ga), OFF);
    run(1);
    check("lit_c4_value", int'(dut_a.pwm_value), 2);
    run(4);
    check("lit_c8_value", int'(dut_a.pwm_value), 4);
    run(4);
    check("lit_c12_value_b", int'(dut_b.pwm_value), 9);
    run(4);
    check("lit_c16_value_b", int'(dut_b.pwm_value), 10);
    check("lit_c16_state_b", int'(dut_b.current_state), int'(RED_DEC));
    run(4);
    check("lit_c20_value", int'(dut_a.pwm_value), 10);
    check("lit_c20_state", int'(dut_a.current_state), int'(RED_DEC));
    check("lit_c20_G", int'(ga), ON);
    run(4);
    check("lit_c24_value", int'(dut_a.pwm_value), 8);
    run(8);
    check("lit_c32_state_b", int'(dut_b.current_state), int'(BLUE_INC));
    check("lit_c32_value_b", int'(dut_b.pwm_value), 0);
    run(88);
    check("lit_c120_state", int'(dut_a.current_state), int'(GREEN_INC));
    check("lit_c120_value", int'(dut_a.pwm_value), 0);

    // Reset in the middle of a BLUE_INC ramp.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      run(1);
      if (dut_a.current_state == BLUE_INC) found = 1'b1;
    end
    check("wait_blue_inc", int'(found), 1);
    run(6);
    rst_n = 1'b0;
    run(1);
    check("lit_mid_state", int'(dut_a.current_state), int'(GREEN_INC));
    check("lit_mid_value", int'(dut_a.pwm_value), 0);
    check("lit_mid_R", int'(ra), ON);
    check("lit_mid_G", int'(ga), OFF);
    check("lit_mid_B", int'(ba), OFF);
    rst_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      run($urandom_range(1, 150));
      if ($urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        run($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
